// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: one quotient bit per clock, divide-by-zero flag, Busy/Ready handshake.
// Define DIV_SIGNED_EN for two's-complement operands (quotient truncates toward zero).
module div_restoring_seq #(
  parameter  int N    = 6,
  localparam int CNTW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         Ready,
  output logic         Busy,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         DivZero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      dvd_q, dvd_d;
  logic [N-1:0]      dvs_q, dvs_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      q_q, q_d;
  logic [N-1:0]      m_q, m_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]      quo_q, quo_d;
  logic [N-1:0]      rem_q, rem_d;
  logic              dz_q, dz_d;
`ifdef DIV_SIGNED_EN
  logic              sd_q, sd_d;
  logic              ss_q, ss_d;
`endif

  logic [N-1:0]      mag_dvd;
  logic [N-1:0]      mag_dvs;
  logic [N:0]        a_sh;
  logic [N:0]        diff;

  // A's top bit is always zero between iterations, so only N bits are stored;
  // the shifted value and difference are N+1 bits so the borrow is never lost.
  always_comb begin
`ifdef DIV_SIGNED_EN
    mag_dvd = dvd_q[N-1] ? (-dvd_q) : dvd_q;
    mag_dvs = dvs_q[N-1] ? (-dvs_q) : dvs_q;
`else
    mag_dvd = dvd_q;
    mag_dvs = dvs_q;
`endif
    a_sh = {a_q, q_q[N-1]};
    diff = a_sh - {1'b0, m_q};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    sd_d    = sd_q;
    ss_d    = ss_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          dvd_d   = Dividend;
          dvs_d   = Divisor;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          q_d     = mag_dvd;
          m_d     = mag_dvs;
          a_d     = '0;
`ifdef DIV_SIGNED_EN
          sd_d    = dvd_q[N-1];
          ss_d    = dvs_q[N-1];
`endif
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (diff[N]) begin
          a_d = a_sh[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end else begin
          a_d = diff[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(N - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
`ifdef DIV_SIGNED_EN
        quo_d = (sd_q ^ ss_q) ? (-q_q) : q_q;
        rem_d = sd_q ? (-a_q) : a_q;
`else
        quo_d = q_q;
        rem_d = a_q;
`endif
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      sd_q    <= 1'b0;
      ss_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      sd_q    <= sd_d;
      ss_q    <= ss_d;
`endif
    end
  end

  assign Ready     = (state_q == S_DONE);
  assign Busy      = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq: scoreboard of expected results checked when Ready rises.
module tb_div_restoring_seq;
  localparam int N   = 6;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic         Ready;
  logic         Busy;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         DivZero;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  div_restoring_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Ready(Ready), .Busy(Busy), .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
`ifdef DIV_SIGNED_EN
    int sa;
    int sv;
`endif
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa   = int'($signed(a));
      sv   = int'($signed(b));
      e.q  = N'(sa / sv);
      e.r  = N'(sa % sv);
`else
      e.q  = a / b;
      e.r  = a % b;
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    sbq.push_back(model(a, b));
    @(negedge clk);
    Start    = 1'b0;
    Dividend = N'($urandom);
    Divisor  = N'($urandom);
  endtask

  task automatic wait_ready(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    while (Ready !== 1'b1 && n < 64) begin
      if (Busy === 1'b1) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({Ready, Busy, DivZero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {Ready, Busy, DivZero});
    end
    n_tests++;
    if ({Quotient, Remainder} !== '0) begin
      n_fail++; $display("FAIL reset_data: got q=%0d r=%0d expected 0 0", Quotient, Remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n, nb;
    exp_t e;
    logic [N-1:0] held;
    start_op(6'd45, 6'd7);
    wait_ready(n, nb);
    n_tests++;
    if (n != LAT) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected %0d", n, LAT);
    end
    n_tests++;
    if (nb != LAT) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", nb, LAT);
    end
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder, DivZero} !== {e.q, e.r, e.dz}) begin
      n_fail++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         Quotient, Remainder, DivZero, e.q, e.r, e.dz);
    end
    held = Quotient;
    repeat (3) @(negedge clk);
    n_tests++;
    if (Ready !== 1'b1 || Quotient !== held) begin
      n_fail++; $display("FAIL basic_hold: got ready=%b q=%0d expected ready=1 q=%0d", Ready, Quotient, held);
    end
  endtask

  task automatic test_table();
    logic [N-1:0] va[8] = '{6'd5, 6'd3,  6'd63, 6'd63, 6'd0, 6'd1,  6'd32, 6'd0};
    logic [N-1:0] vb[8] = '{6'd0, 6'd10, 6'd1,  6'd63, 6'd5, 6'd63, 6'd0,  6'd0};
    logic [N-1:0] a, b;
    int n, nb, exp_lat;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) begin
        a = va[i]; b = vb[i];
      end else begin
        a = N'($urandom);
        b = (i % 5 == 0) ? '0 : N'($urandom_range(1, 63));
      end
      start_op(a, b);
      wait_ready(n, nb);
      exp_lat = (b == '0) ? 1 : LAT;
      n_tests++;
      if (n != exp_lat) begin
        n_fail++; $display("FAIL table_latency[%0d] %0d/%0d: got %0d expected %0d", i, a, b, n, exp_lat);
      end
      if (sbq.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL table_scoreboard[%0d]: got empty queue expected entry", i);
      end else begin
        e = sbq.pop_front();
        n_tests++;
        if ({Quotient, Remainder, DivZero} !== {e.q, e.r, e.dz}) begin
          n_fail++; $display("FAIL table_result[%0d] %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                             i, a, b, Quotient, Remainder, DivZero, e.q, e.r, e.dz);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int n, nb;
    exp_t e;
    start_op(6'd45, 6'd7);
    repeat (3) @(negedge clk);
    Start = 1'b1; Dividend = 6'd9; Divisor = 6'd2;
    @(negedge clk);
    Start = 1'b0;
    wait_ready(n, nb);
    n_tests++;
    if (n + 4 != LAT) begin
      n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", n + 4, LAT);
    end
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder, DivZero} !== {e.q, e.r, e.dz}) begin
      n_fail++; $display("FAIL ignore_result: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         Quotient, Remainder, DivZero, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    start_op(6'd45, 6'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e = sbq.pop_front();
    n_tests++;
    if ({Ready, Busy, DivZero} !== 3'b000 || {Quotient, Remainder} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got ready=%b busy=%b dz=%b q=%0d r=%0d expected all 0",
                         Ready, Busy, DivZero, Quotient, Remainder);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (Busy !== 1'b0 || Ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle: got busy=%b ready=%b expected 0 0", Busy, Ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, nb;
    exp_t e;
    start_op(6'd50, 6'd3);
    wait_ready(n, nb);
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder} !== {e.q, e.r}) begin
      n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d expected q=%0d r=%0d", Quotient, Remainder, e.q, e.r);
    end
    Start = 1'b1; Dividend = 6'd20; Divisor = 6'd4;
    sbq.push_back(model(6'd20, 6'd4));
    @(negedge clk);
    Dividend = N'($urandom); Divisor = N'($urandom);
    n_tests++;
    if (Ready !== 1'b0 || Quotient !== e.q) begin
      n_fail++; $display("FAIL b2b_drop_hold: got ready=%b q=%0d expected ready=0 q=%0d", Ready, Quotient, e.q);
    end
    wait_ready(n, nb);
    n_tests++;
    if (n != LAT) begin
      n_fail++; $display("FAIL b2b_ready_low: got %0d expected %0d", n, LAT);
    end
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder, DivZero} !== {e.q, e.r, e.dz}) begin
      n_fail++; $display("FAIL b2b_second: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         Quotient, Remainder, DivZero, e.q, e.r, e.dz);
    end
    Dividend = 6'd7; Divisor = 6'd0;
    sbq.push_back(model(6'd7, 6'd0));
    @(negedge clk);
    Start = 1'b0;
    wait_ready(n, nb);
    n_tests++;
    if (n != 1) begin
      n_fail++; $display("FAIL b2b_divzero_latency: got %0d expected 1", n);
    end
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder, DivZero} !== {e.q, e.r, e.dz}) begin
      n_fail++; $display("FAIL b2b_divzero: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         Quotient, Remainder, DivZero, e.q, e.r, e.dz);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int n, nb;
    exp_t e;
    start_op(6'b101100, 6'd6);
    wait_ready(n, nb);
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder} !== {6'b111101, 6'b111110} || {Quotient, Remainder} !== {e.q, e.r}) begin
      n_fail++; $display("FAIL signed_m20_6: got q=%b r=%b expected q=111101 r=111110", Quotient, Remainder);
    end
    start_op(6'b100000, 6'b111111);
    wait_ready(n, nb);
    e = sbq.pop_front();
    n_tests++;
    if ({Quotient, Remainder} !== {6'b100000, 6'b000000} || {Quotient, Remainder} !== {e.q, e.r}) begin
      n_fail++; $display("FAIL signed_m32_m1: got q=%b r=%b expected q=100000 r=000000", Quotient, Remainder);
    end
    n_tests++;
    if (n != LAT) begin
      n_fail++; $display("FAIL signed_latency: got %0d expected %0d", n, LAT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_table();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
